instr_encoder: RTL

Sequential MIPS instruction encoder and program loader for the pipeline's instruction memory. It accepts a stream of symbolic instructions over a valid/ready handshake, then packs each one into the 32-bit word format the ID-stage control unit decodes. Each packed word is written to consecutive instruction-memory addresses starting at `BASE_ADDR`. It runs in the same clock domain as the pipeline and is active only before the core is released from reset or stall.

---
 rtl/instr_encoder_if.sv | 32 +++
 rtl/instr_encoder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_if
// Brief    : Symbolic-instruction stream and instruction-memory write port.
// Revision : 1.0
// ============================================================================
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Packs symbolic MIPS instructions and loads them into imem.
// Revision : 1.0
// ============================================================================
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    instr_encoder_if.slave   bus,
    input  wire logic        start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [ADDR_W:0]  count
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;
    localparam logic [1:0] c_ERR  = 2'd3;

    localparam logic [ADDR_W-1:0] c_BASE = ADDR_W'(BASE_ADDR);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       w_word;
    logic              w_xfer;
    logic              w_legal;
    logic              w_full;
    logic              w_write;
    logic              w_restart;

    assign w_xfer    = bus.in_valid && (r_state == c_LOAD);
    assign w_legal   = (bus.in_op <= 4'd10);
    // Capacity is judged by the word count; the pointer alone wraps silently.
    assign w_full    = r_count[ADDR_W];
    assign w_write   = w_xfer && w_legal && !w_full;
    assign w_restart = start && (r_state != c_LOAD);

    always_comb begin
        w_word = 32'h0000_0000;
        case (bus.in_op)
            4'd0:    w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100000};
            4'd1:    w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100010};
            4'd2:    w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100100};
            4'd3:    w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100101};
            4'd4:    w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b101010};
            4'd5:    w_word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd6:    w_word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd7:    w_word = {6'b000010, bus.in_target};
            4'd8:    w_word = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd9:    w_word = {6'b000101, bus.in_rs, bus.in_rt, bus.in_imm};
            default: w_word = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_LOAD: begin
                if (w_xfer) begin
                    if (bus.in_op == 4'd11) begin
                        w_next_state = c_DONE;
                    end else if (!w_legal || w_full) begin
                        w_next_state = c_ERR;
                    end
                end
            end
            default: begin
                if (start) begin
                    w_next_state = c_LOAD;
                end
            end
        endcase
    end

    always_comb begin
        bus.in_ready = (r_state == c_LOAD);
        busy         = (r_state == c_LOAD);
        done         = (r_state == c_DONE);
        error        = (r_state == c_ERR);
    end

    // Datapath: pointer/count and the one-cycle registered write presentation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= c_BASE;
            r_count <= '0;
            r_we    <= 1'b0;
            r_addr  <= c_BASE;
            r_wdata <= 32'h0000_0000;
        end else begin
            r_we <= w_write;
            if (w_restart) begin
                r_ptr   <= c_BASE;
                r_count <= '0;
            end else if (w_write) begin
                r_addr  <= r_ptr;
                r_wdata <= w_word;
                r_ptr   <= r_ptr + 1'b1;
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign count         = r_count;

endmodule
`default_nettype wire
